output_vc_arbiter: RTL and testbench
====================================

OUTPUT_VC_ARBITER -- requirements
Module: output_vc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits (>= 8).
REQ-002 Parameter VC_DEPTH, default 4, per-input FIFO depth in flits (power of 2, >= 2).
REQ-003 Parameter NUM_PORTS, default 5, number of input ports (2..8); port 0 = North, 1 = South, 2 = East, 3 = West, 4 = Local.
REQ-004 Parameter PKT_MODE, default 0: 0 = single-flit packets; 1 = wormhole, tail flag = flit bit [DATA_WIDTH-1].
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 in_data  input  NUM_PORTS*DATA_WIDTH  flit from port i on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 in_valid  input  NUM_PORTS  per-port flit valid.
REQ-009 in_ready  output  NUM_PORTS  per-port FIFO not full.
REQ-010 out_data  output  DATA_WIDTH  registered output flit.
REQ-011 out_valid  output  1  registered output valid.
REQ-012 out_ready  input  1  downstream accepts flit.
REQ-013 vc_nonempty  output  NUM_PORTS  per-port FIFO holds >= 1 flit (status).

Function
REQ-014 Each port SHALL own a FIFO of VC_DEPTH flits with a count of width clog2(VC_DEPTH)+1; pointers wrap modulo VC_DEPTH.
REQ-015 in_ready[i] SHALL equal (count[i] != VC_DEPTH) && rst_n; derived only from registered state, never from in_valid or out_ready.
REQ-016 A flit SHALL be written to FIFO i at the edge where in_valid[i] && in_ready[i]; in_valid without in_ready SHALL be ignored (no overwrite).
REQ-017 Output stage is free when !out_valid || out_ready; only when free SHALL a flit be popped from a FIFO and loaded into out_data/out_valid.
REQ-018 While out_valid && !out_ready, out_data and out_valid SHALL hold unchanged; no FIFO pops.
REQ-019 Stage free and no eligible requester: out_valid SHALL go 0 next edge; out_data holds last value.
REQ-020 Arbitration SHALL be round-robin across all NUM_PORTS equally: search starts at (last_grant+1) mod NUM_PORTS; no fixed-priority or starvation-prone port.
REQ-021 last_grant SHALL update only on edges where a pop occurs.
REQ-022 Simultaneous write and pop on the same FIFO SHALL leave count unchanged; write to full FIFO is impossible per REQ-015 even if a pop occurs same cycle.
REQ-023 Minimum latency: flit written at edge k into empty FIFO with free stage and winning arbitration SHALL appear with out_valid=1 after edge k+1.
REQ-024 Throughput: one flit per cycle sustained when out_ready=1 and any FIFO nonempty.
REQ-025 PKT_MODE=1: popping a flit with tail bit 0 SHALL lock the output to that port; while locked only that port is eligible; lock clears at the edge its tail flit (bit=1) is popped.
REQ-026 PKT_MODE=1, locked port FIFO empty: no pop, out_valid drops per REQ-019, lock held; other ports SHALL NOT be granted.
REQ-027 PKT_MODE=0: tail bit ignored, no lock; every pop is a fresh arbitration.
REQ-028 Flit order within one port SHALL be preserved; no flit duplicated or lost.

Reset
REQ-029 With rst_n=0 at an edge: all FIFO counts and pointers 0, out_valid=0, out_data=0, last_grant=NUM_PORTS-1 (port 0 first), lock cleared.
REQ-030 While rst_n=0, in_ready SHALL be all 0 and no writes accepted; reset mid-packet SHALL discard all buffered and in-flight flits.
REQ-031 First edge with rst_n=1 SHALL accept writes; in_ready high from that cycle.

Verification
REQ-032 Fill port 0 with 5 flits, out_ready=0, VC_DEPTH=4 -> 4 accepted, in_ready[0]=0 after 4th, 5th ignored; release -> 0x0..0x3 in order.
REQ-033 All 5 ports hold 2 flits, out_ready=1 -> output order ports 0,1,2,3,4,0,1,2,3,4, one per cycle, no gaps.
REQ-034 out_ready toggled 1,0,0,1 while out_valid=1 with 0xAAAA5555 -> out_data stable during stall, no flit lost or repeated.
REQ-035 PKT_MODE=1: port 1 sends head 0x00000011, body gap 3 cycles, tail 0x80000033; port 2 pending -> port 2 withheld until tail 0x80000033 output, then granted.
REQ-036 rst_n=0 for one edge with 3 flits buffered and out_valid=1 -> out_valid=0, out_data=0, vc_nonempty=0, in_ready=0 during reset, all 1 after.

Source files
------------

// File: rtl/output_vc_arbiter.sv
// -----------------------------------------------------------------------------
// output_vc_arbiter
//
// Multi-input output arbiter for a router output port. Each input port owns a
// small flit FIFO; a round-robin arbiter picks one nonempty FIFO per cycle and
// loads its head flit into a single registered output stage with a
// valid/ready handshake toward the downstream router or sink.
//
// In wormhole mode (PKT_MODE=1) the output is held by one input from its head
// flit until its tail flit (bit DATA_WIDTH-1 set) has been forwarded, so flits
// of different packets never interleave on the output link.
//
// Parameters
//   DATA_WIDTH  flit width in bits (>= 8)
//   VC_DEPTH    per-input FIFO depth in flits (power of 2, >= 2)
//   NUM_PORTS   number of input ports (2..8): 0=N, 1=S, 2=E, 3=W, 4=Local
//   PKT_MODE    0 = single-flit packets, 1 = wormhole with tail flag in MSB
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   in_data      flit from port i on bits [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid     per-port flit valid
//   in_ready     per-port FIFO not full (registered state only, low in reset)
//   out_data     registered output flit
//   out_valid    registered output valid
//   out_ready    downstream accepts the output flit
//   vc_nonempty  per-port FIFO holds at least one flit
// -----------------------------------------------------------------------------
module output_vc_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int VC_DEPTH   = 4,
  parameter int NUM_PORTS  = 5,
  parameter int PKT_MODE   = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            vc_nonempty
);

  localparam int AW = $clog2(VC_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]                 wr_en;
  logic [NUM_PORTS-1:0]                 rd_en;
  logic [NUM_PORTS-1:0]                 eligible;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head_data;

  logic [PW-1:0]         last_grant;
  logic [PW-1:0]         grant_idx;
  logic                  grant_found;
  logic                  stage_free;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;

  logic                  locked;
  logic [PW-1:0]         lock_port;

  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p0;

  // ---------------------------------------------------------------------------
  // Stage: per-port input FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_vc
    logic [DATA_WIDTH-1:0] mem [VC_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    // in_ready gated by rst_n so nothing is accepted while reset is held.
    assign in_ready[i]    = (count != CW'(VC_DEPTH)) && rst_n;
    assign wr_en[i]       = in_valid[i] && in_ready[i];
    assign rd_en[i]       = pop && (grant_idx == PW'(i));
    assign vc_nonempty[i] = (count != '0);
    // While locked, only the packet owner may compete for the output.
    assign eligible[i]    = (count != '0) && (!locked || (lock_port == PW'(i)));
    assign head_data[i]   = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en[i]) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en[i]) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_en[i], rd_en[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en[i]) mem[wr_ptr] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage: round-robin arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    // Offsets 1..NUM_PORTS visit every port once, ending on last_grant itself,
    // so the most recent winner has the lowest priority.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_PORTS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  assign stage_free = !vld_p0 || out_ready;
  assign pop        = stage_free && grant_found;
  assign pop_data   = head_data[grant_idx];

  // ---------------------------------------------------------------------------
  // Stage: registered output and packet lock
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      last_grant <= PW'(NUM_PORTS - 1);
      locked     <= 1'b0;
      lock_port  <= '0;
    end else if (stage_free) begin
      // No winner: drop valid but keep the last flit on the data bus.
      vld_p0 <= grant_found;
      if (grant_found) begin
        data_p0    <= pop_data;
        last_grant <= grant_idx;
        if (PKT_MODE != 0) begin
          locked    <= !pop_data[DATA_WIDTH-1];
          lock_port <= grant_idx;
        end
      end
    end
  end

  assign out_data  = data_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_output_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_vc_arbiter
//
// Directed bench for output_vc_arbiter. Two instances share one clock:
// dut_a runs single-flit mode, dut_b runs wormhole mode. Inputs change 1 time
// unit after each rising edge and outputs are compared at that same point.
// -----------------------------------------------------------------------------
module tb_output_vc_arbiter;

  localparam int DW = 32;
  localparam int NP = 5;
  localparam int VD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n_a, rst_n_b;
  logic [NP*DW-1:0]  in_data_a, in_data_b;
  logic [NP-1:0]     in_valid_a, in_valid_b;
  logic [NP-1:0]     in_ready_a, in_ready_b;
  logic [DW-1:0]     out_data_a, out_data_b;
  logic              out_valid_a, out_valid_b;
  logic              out_ready_a, out_ready_b;
  logic [NP-1:0]     vc_nonempty_a, vc_nonempty_b;

  int n_checks = 0;
  int n_errors = 0;

  output_vc_arbiter #(.DATA_WIDTH(DW), .VC_DEPTH(VD), .NUM_PORTS(NP), .PKT_MODE(0)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n_a),
    .in_data     (in_data_a),
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .out_data    (out_data_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready_a),
    .vc_nonempty (vc_nonempty_a)
  );

  output_vc_arbiter #(.DATA_WIDTH(DW), .VC_DEPTH(VD), .NUM_PORTS(NP), .PKT_MODE(1)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n_b),
    .in_data     (in_data_b),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .out_data    (out_data_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready_b),
    .vc_nonempty (vc_nonempty_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n_a     = 1'b0;
    rst_n_b     = 1'b0;
    in_data_a   = '0;
    in_data_b   = '0;
    in_valid_a  = '0;
    in_valid_b  = '0;
    out_ready_a = 1'b0;
    out_ready_b = 1'b1;
    step();
    step();

    // Reset state
    check("rst_out_valid", out_valid_a, 0);
    check("rst_out_data", out_data_a, 0);
    check("rst_in_ready", in_ready_a, 0);
    check("rst_nonempty", vc_nonempty_a, 0);
    check("rst_in_ready_b", in_ready_b, 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    #1;
    check("rel_in_ready", in_ready_a, 5'h1f);

    // Fill port 0 behind a stalled output holding a flit from port 4
    in_data_a[4*DW +: DW] = 32'hAA;
    in_valid_a = 5'b10000;
    step();
    in_valid_a = '0;
    step();
    check("t1_hold_valid", out_valid_a, 1);
    check("t1_hold_data", out_data_a, 32'hAA);
    for (int n = 0; n < 5; n++) begin
      in_data_a[0 +: DW] = DW'(n);
      in_valid_a[0] = 1'b1;
      step();
      check($sformatf("t1_in_ready_%0d", n), in_ready_a[0], (n < 3) ? 1 : 0);
    end
    in_valid_a = '0;
    check("t1_stall_data", out_data_a, 32'hAA);
    check("t1_nonempty", vc_nonempty_a, 5'b00001);
    out_ready_a = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("t1_drain_valid_%0d", n), out_valid_a, 1);
      check($sformatf("t1_drain_data_%0d", n), out_data_a, n);
    end
    step();
    check("t1_idle_valid", out_valid_a, 0);
    check("t1_idle_data", out_data_a, 3);
    check("t1_idle_nonempty", vc_nonempty_a, 0);

    // Round-robin over all ports, two flits each
    rst_n_a = 1'b0;
    step();
    rst_n_a = 1'b1;
    for (int p = 0; p < NP; p++) in_data_a[p*DW +: DW] = DW'(p * 16);
    in_valid_a = 5'h1f;
    step();
    for (int p = 0; p < NP; p++) in_data_a[p*DW +: DW] = DW'(p * 16 + 1);
    step();
    in_valid_a = '0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      check($sformatf("t2_rr_valid_%0d", k), out_valid_a, 1);
      check($sformatf("t2_rr_data_%0d", k), out_data_a, (k % 5) * 16 + (k / 5));
    end
    step();
    check("t2_idle_valid", out_valid_a, 0);

    // Output stall with out_ready toggling
    out_ready_a = 1'b0;
    in_data_a[2*DW +: DW] = 32'hAAAA5555;
    in_valid_a = 5'b00100;
    step();
    in_data_a[2*DW +: DW] = 32'h12345678;
    step();
    in_valid_a = '0;
    check("t3_first_valid", out_valid_a, 1);
    check("t3_first_data", out_data_a, 32'hAAAA5555);
    step();
    check("t3_stall0_data", out_data_a, 32'hAAAA5555);
    out_ready_a = 1'b1;
    step();
    check("t3_second_data", out_data_a, 32'h12345678);
    out_ready_a = 1'b0;
    step();
    check("t3_stall1_data", out_data_a, 32'h12345678);
    check("t3_stall1_valid", out_valid_a, 1);
    step();
    check("t3_stall2_data", out_data_a, 32'h12345678);
    out_ready_a = 1'b1;
    step();
    check("t3_end_valid", out_valid_a, 0);
    check("t3_end_data", out_data_a, 32'h12345678);
    check("t3_end_nonempty", vc_nonempty_a, 0);

    // Wormhole lock: port 2 waits for the tail of port 1's packet
    in_data_b[1*DW +: DW] = 32'h00000011;
    in_valid_b = 5'b00010;
    step();
    in_data_b[2*DW +: DW] = 32'h80000022;
    in_valid_b = 5'b00100;
    step();
    in_valid_b = '0;
    check("t4_head_valid", out_valid_b, 1);
    check("t4_head_data", out_data_b, 32'h00000011);
    for (int g = 0; g < 3; g++) begin
      step();
      check($sformatf("t4_gap_valid_%0d", g), out_valid_b, 0);
      check($sformatf("t4_gap_data_%0d", g), out_data_b, 32'h00000011);
      check($sformatf("t4_gap_pending_%0d", g), vc_nonempty_b, 5'b00100);
    end
    in_data_b[1*DW +: DW] = 32'h80000033;
    in_valid_b = 5'b00010;
    step();
    in_valid_b = '0;
    check("t4_tail_wr_valid", out_valid_b, 0);
    step();
    check("t4_tail_valid", out_valid_b, 1);
    check("t4_tail_data", out_data_b, 32'h80000033);
    step();
    check("t4_p2_valid", out_valid_b, 1);
    check("t4_p2_data", out_data_b, 32'h80000022);
    step();
    check("t4_idle_valid", out_valid_b, 0);

    // Reset with buffered flits and a valid output
    out_ready_a = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_data_a[3*DW +: DW] = DW'(32'h31 + n);
      in_valid_a = 5'b01000;
      step();
    end
    in_valid_a = '0;
    check("t5_pre_valid", out_valid_a, 1);
    check("t5_pre_data", out_data_a, 32'h31);
    check("t5_pre_nonempty", vc_nonempty_a, 5'b01000);
    rst_n_a = 1'b0;
    in_data_a[0 +: DW] = 32'hDEAD;
    in_valid_a = 5'b00001;
    #1;
    check("t5_rst_in_ready_comb", in_ready_a, 0);
    step();
    check("t5_rst_valid", out_valid_a, 0);
    check("t5_rst_data", out_data_a, 0);
    check("t5_rst_nonempty", vc_nonempty_a, 0);
    check("t5_rst_in_ready", in_ready_a, 0);
    rst_n_a = 1'b1;
    in_data_a[1*DW +: DW] = 32'h77;
    in_valid_a = 5'b00010;
    #1;
    check("t5_rel_in_ready", in_ready_a, 5'h1f);
    step();
    in_valid_a = '0;
    check("t5_rel_nonempty", vc_nonempty_a, 5'b00010);
    check("t5_rel_valid", out_valid_a, 0);
    out_ready_a = 1'b1;
    step();
    check("t5_out_valid", out_valid_a, 1);
    check("t5_out_data", out_data_a, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
